// File: rtl/mult_32_if.sv
// Operand/result bus between a requester and the mult_32 shift-and-add multiplier.
// Signals: init (start), A/B (unsigned operands), pp (registered product), done (1-cycle strobe).
// Modports: master drives init/A/B and observes pp/done; slave is the multiplier side.
interface mult_32_if #(
  parameter int N = 16
);
  logic           init;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] pp;
  logic           done;

  modport master (output init, output A, output B, input pp, input done);
  modport slave  (input init, input A, input B, output pp, output done);
endinterface

// File: rtl/mult_32.sv
// Sequential unsigned NxN -> 2N multiplier, one multiplier bit per clock (shift-and-add).
// Ports: clk, rst (sync, active-high), bus (mult_32_if.slave: init, A, B in; pp, done out).
// Latency: init sampled at edge k -> pp/done valid after edge k+17; done lasts one cycle.
module mult_32 #(
  parameter int N = 16
) (
  input logic        clk,
  input logic        rst,
  mult_32_if.slave   bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] areg_q, areg_d;
  logic [N-1:0]   breg_q, breg_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] pp_q, pp_d;
  logic           done_q, done_d;

  // Accumulator value including this cycle's partial product; also feeds pp on
  // the last iteration so the final add is never lost.
  logic [2*N-1:0] acc_sum;
  assign acc_sum = acc_q + (breg_q[0] ? areg_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pp_d    = pp_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.init) state_d = LOAD;
      end
      LOAD: begin
        // Operands are captured only here; later bus changes cannot disturb the run.
        areg_d  = {{N{1'b0}}, bus.A};
        breg_d  = bus.B;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        acc_d  = acc_sum;
        areg_d = areg_q << 1;
        breg_d = breg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // pp and done are registered together on entry to DONE, so the
          // strobe and the product appear on the same edge.
          pp_d    = acc_sum;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pp   = pp_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_32.sv
module tb_mult_32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_pp = 32'h0;

  mult_32_if bus ();

  mult_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product: plain 32-bit arithmetic on the zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wa, wb;
    wa = {16'h0, a};
    wb = {16'h0, b};
    return wa * wb;
  endfunction

  // Starts an operation, holds init for 'hold' cycles, optionally disturbs the
  // bus mid-run, then checks latency, product, strobe width and quiet afterwards.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit poke);
    logic [31:0] prev;
    logic [31:0] want;
    int n;
    int extra;
    bit seen;
    prev = exp_pp;
    want = ref_mul(a, b);
    bus.A = a;
    bus.B = b;
    bus.init = 1'b1;
    @(negedge clk);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      if (n >= hold - 1) bus.init = 1'b0;
      if (poke && n == 5) begin
        bus.A = ~a;
        bus.B = ~b;
        bus.init = 1'b1;
      end
      if (n == 8) check({tag, "_no_partial"}, bus.pp, prev);
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, n, 17);
    check({tag, "_pp"}, bus.pp, want);
    exp_pp = want;
    @(negedge clk);
    check({tag, "_done_drop"}, {31'h0, bus.done}, 32'h0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    check({tag, "_no_extra_done"}, extra, 0);
    check({tag, "_pp_hold"}, bus.pp, exp_pp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [15:0] ra, rb;

    rst = 1'b1;
    bus.init = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    check("reset_pp", bus.pp, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("f7x7f", 16'h00F7, 16'h007F, 2, 1'b0);
    check("f7x7f_const", exp_pp, 32'h00007A89);
    run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 1, 1'b0);
    run_op("zero_a", 16'h0000, 16'h1234, 1, 1'b0);
    run_op("zero_b", 16'h1234, 16'h0000, 1, 1'b0);
    run_op("one_x_ffff", 16'h0001, 16'hFFFF, 1, 1'b0);
    run_op("msb_x2", 16'h8000, 16'h0002, 1, 1'b0);
    run_op("busy_poke", 16'h1357, 16'h2468, 1, 1'b1);

    // Reset during the 8th ITER cycle: operation abandoned, no done afterwards.
    bus.A = 16'hABCD;
    bus.B = 16'h00FF;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pp", bus.pp, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    rst = 1'b0;
    exp_pp = 32'h0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);
    run_op("after_abort", 16'hABCD, 16'h00FF, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op("random", ra, rb, 1 + (i % 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
